// File: rtl/rf_ex_hazard_ctrl_pkg.sv
// Shared types for the RF/EX hazard controller: scoreboard entry layout,
// the zero-register index and the diagnostic pipeline-state encoding.
package controlPkg;

   localparam logic [4:0] XZR = 5'd31;

   typedef struct packed {
      logic       valid;
      logic       RegWrite;
      logic       MemRead;
      logic       set_flags;
      logic [4:0] addr;
   } sb_entry_t;

   typedef enum logic [1:0] {
      HZ_RUN   = 2'd0,
      HZ_STALL = 2'd1,
      HZ_FLUSH = 2'd2
   } hz_state_t;

endpackage

// File: rtl/rf_ex_hazard_ctrl_if.sv
// Bundle of decode-stage inputs and pipeline-control outputs exchanged between
// the ID stage (master) and the hazard controller (slave).
interface rf_ex_hazard_ctrl_if #(
   parameter int CNT_W = 16
);

   logic                  id_valid;
   logic [4:0]            id_rn_addr;
   logic [4:0]            id_rm_addr;
   logic                  id_uses_rn;
   logic                  id_uses_rm;
   logic                  id_reads_flags;
   logic                  id_RegWrite;
   logic                  id_MemRead;
   logic                  id_set_flags;
   logic [4:0]            id_reg_write_addr;
   logic                  ex_branch_taken;

   logic                  bubble;
   logic                  pc_write_en;
   logic                  if_id_write_en;
   logic                  if_id_flush;
   logic                  load_use_stall;
   logic                  flag_stall;
   logic [CNT_W-1:0]      stall_cnt;
   logic [CNT_W-1:0]      flush_cnt;

   // Scoreboard contents and decoded state, exported for debug visibility
   controlPkg::sb_entry_t ex_entry;
   controlPkg::sb_entry_t mem_entry;
   controlPkg::sb_entry_t wb_entry;
   controlPkg::hz_state_t hz_state;

   modport master (
      output id_valid, id_rn_addr, id_rm_addr, id_uses_rn, id_uses_rm,
             id_reads_flags, id_RegWrite, id_MemRead, id_set_flags,
             id_reg_write_addr, ex_branch_taken,
      input  bubble, pc_write_en, if_id_write_en, if_id_flush,
             load_use_stall, flag_stall, stall_cnt, flush_cnt,
             ex_entry, mem_entry, wb_entry, hz_state
   );

   modport slave (
      input  id_valid, id_rn_addr, id_rm_addr, id_uses_rn, id_uses_rm,
             id_reads_flags, id_RegWrite, id_MemRead, id_set_flags,
             id_reg_write_addr, ex_branch_taken,
      output bubble, pc_write_en, if_id_write_en, if_id_flush,
             load_use_stall, flag_stall, stall_cnt, flush_cnt,
             ex_entry, mem_entry, wb_entry, hz_state
   );

endinterface

// File: rtl/rf_ex_hazard_ctrl_sb_stage_reg.sv
// One scoreboard stage: a register of sb_entry_t cleared by the async
// active-low reset.
module sb_stage_reg
   import controlPkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  sb_entry_t d_i,
   output sb_entry_t q_o
);

   sb_entry_t entry_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         entry_q <= '0;
      end else begin
         entry_q <= d_i;
      end
   end

   assign q_o = entry_q;

endmodule

// File: rtl/rf_ex_hazard_ctrl.sv
// RF/EX producer-side hazard controller: chooses RUN, STALL or FLUSH each cycle
// from the EX scoreboard entry and the decoded ID instruction.
module rf_ex_hazard_ctrl
   import controlPkg::*;
#(
   parameter bit FLAG_FWD = 1'b0,
   parameter int CNT_W    = 16
) (
   input logic               clk,
   input logic               reset,
   rf_ex_hazard_ctrl_if.slave hz
);

   sb_entry_t  ex_q;
   sb_entry_t  mem_q;
   sb_entry_t  wb_q;
   sb_entry_t  ex_d;

   logic       loadHit;
   logic       flagHit;
   hz_state_t  hzState;

   logic       bubble;
   logic       pcWriteEn;
   logic       ifIdWriteEn;
   logic       ifIdFlush;
   logic       loadUseStall;
   logic       flagStall;

   logic [CNT_W-1:0] stallCnt_q;
   logic [CNT_W-1:0] stallCnt_d;
   logic [CNT_W-1:0] flushCnt_q;
   logic [CNT_W-1:0] flushCnt_d;

   // Only a load still in EX can stall: everything older is forwarded
   always_comb begin
      loadHit = hz.id_valid & ex_q.valid & ex_q.MemRead & ex_q.RegWrite &
                (ex_q.addr != XZR) &
                ((hz.id_uses_rn & (hz.id_rn_addr == ex_q.addr)) |
                 (hz.id_uses_rm & (hz.id_rm_addr == ex_q.addr)));
      flagHit = (FLAG_FWD == 1'b0) & hz.id_valid & ex_q.valid &
                ex_q.set_flags & hz.id_reads_flags;
   end

   always_comb begin
      hzState      = HZ_RUN;
      bubble       = 1'b0;
      pcWriteEn    = 1'b1;
      ifIdWriteEn  = 1'b1;
      ifIdFlush    = 1'b0;
      loadUseStall = 1'b0;
      flagStall    = 1'b0;
      if (hz.ex_branch_taken) begin
         hzState   = HZ_FLUSH;
         bubble    = 1'b1;
         ifIdFlush = 1'b1;
      end else if (loadHit | flagHit) begin
         hzState      = HZ_STALL;
         bubble       = 1'b1;
         pcWriteEn    = 1'b0;
         ifIdWriteEn  = 1'b0;
         loadUseStall = loadHit;
         flagStall    = flagHit;
      end
      // Reset overrides the outputs immediately, without waiting for a clock
      if (!reset) begin
         bubble       = 1'b1;
         pcWriteEn    = 1'b0;
         ifIdWriteEn  = 1'b0;
         ifIdFlush    = 1'b0;
         loadUseStall = 1'b0;
         flagStall    = 1'b0;
      end
   end

   always_comb begin
      ex_d = '0;
      if (!bubble) begin
         ex_d.valid     = hz.id_valid;
         ex_d.RegWrite  = hz.id_RegWrite;
         ex_d.MemRead   = hz.id_MemRead;
         ex_d.set_flags = hz.id_set_flags;
         ex_d.addr      = hz.id_reg_write_addr;
      end
   end

   sb_stage_reg u_sb_ex  (.clk(clk), .reset(reset), .d_i(ex_d),  .q_o(ex_q));
   sb_stage_reg u_sb_mem (.clk(clk), .reset(reset), .d_i(ex_q),  .q_o(mem_q));
   sb_stage_reg u_sb_wb  (.clk(clk), .reset(reset), .d_i(mem_q), .q_o(wb_q));

   // Performance counters stick at all-ones rather than wrapping
   always_comb begin
      stallCnt_d = stallCnt_q;
      flushCnt_d = flushCnt_q;
      if ((hzState == HZ_STALL) && (stallCnt_q != '1)) begin
         stallCnt_d = stallCnt_q + CNT_W'(1);
      end
      if ((hzState == HZ_FLUSH) && (flushCnt_q != '1)) begin
         flushCnt_d = flushCnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stallCnt_q <= '0;
         flushCnt_q <= '0;
      end else begin
         stallCnt_q <= stallCnt_d;
         flushCnt_q <= flushCnt_d;
      end
   end

   assign hz.bubble         = bubble;
   assign hz.pc_write_en    = pcWriteEn;
   assign hz.if_id_write_en = ifIdWriteEn;
   assign hz.if_id_flush    = ifIdFlush;
   assign hz.load_use_stall = loadUseStall;
   assign hz.flag_stall     = flagStall;
   assign hz.stall_cnt      = stallCnt_q;
   assign hz.flush_cnt      = flushCnt_q;
   assign hz.ex_entry       = ex_q;
   assign hz.mem_entry      = mem_q;
   assign hz.wb_entry       = wb_q;
   assign hz.hz_state       = hzState;

endmodule
